// File: rtl/ttdll_pkg.sv
// ttdll_pkg: shared types and helpers for the DLL test-chip divider bank.
//   calc_ch_w / calc_frame_w : derive channel-select and frame widths
//   frame_t                  : decoded configuration frame {ch, en, half, phase}
//   ch_state_e               : per-channel divider state
// frame_t is sized for the largest supported configuration (16 channels,
// 16-bit fields); narrower instances zero-extend into it.
package ttdll_pkg;

    localparam int CH_W_MAX  = 4;
    localparam int DIV_W_MAX = 16;

    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int calc_frame_w(input int num_ch, input int div_w);
        return calc_ch_w(num_ch) + 1 + 2 * div_w;
    endfunction

    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic                 en;
        logic [DIV_W_MAX-1:0] half;
        logic [DIV_W_MAX-1:0] phase;
    } frame_t;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_HOLD = 2'd1,
        CH_RUN  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/ttdll_div_ch.sv
// ttdll_div_ch: one programmable divider channel.
//   clk, rst_n  : block clock, async active-low reset
//   pend_v_i    : a pending frame is waiting for this channel
//   pend_i      : the pending frame
//   consume_o   : strobe, pending frame is taken this cycle
//   div_clk_o   : divided clock (registered)
//   active_o    : channel is not IDLE (registered)
// A running channel only accepts a new frame on its high-to-low toggle so
// that no output pulse is ever truncated.
module ttdll_div_ch
    import ttdll_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   pend_v_i,
    input  frame_t pend_i,
    output logic   consume_o,
    output logic   div_clk_o,
    output logic   active_o
);

    ch_state_e        state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] half_q;
    logic             out_q;
    logic             active_q;

    logic [DIV_W-1:0] new_half_s;
    logic [DIV_W-1:0] new_phase_s;
    logic             fall_toggle_s;
    logic             unused_pend_s;

    assign new_half_s    = pend_i.half[DIV_W-1:0];
    assign new_phase_s   = pend_i.phase[DIV_W-1:0];
    // ch field and upper field bits are meaningful only at the bank level
    assign unused_pend_s = ^pend_i;

    // Decide whether the pending frame is accepted this cycle
    always_comb begin
        fall_toggle_s = 1'b0;
        consume_o     = 1'b0;
        if ((state_q == CH_RUN) && (cnt_q == {DIV_W{1'b0}}) && out_q) begin
            fall_toggle_s = 1'b1;
        end else begin
            fall_toggle_s = 1'b0;
        end
        if (pend_v_i && ((state_q == CH_IDLE) || fall_toggle_s)) begin
            consume_o = 1'b1;
        end else begin
            consume_o = 1'b0;
        end
    end

    // Channel FSM: phase hold, then free-running 50% divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_IDLE;
            cnt_q    <= {DIV_W{1'b0}};
            half_q   <= {DIV_W{1'b0}};
            out_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    out_q <= 1'b0;
                    if (pend_v_i && pend_i.en) begin
                        state_q  <= CH_HOLD;
                        cnt_q    <= new_phase_s;
                        half_q   <= new_half_s;
                        active_q <= 1'b1;
                    end else begin
                        active_q <= 1'b0;
                    end
                end
                CH_HOLD: begin
                    if (cnt_q == {DIV_W{1'b0}}) begin
                        state_q <= CH_RUN;
                        out_q   <= 1'b1;
                        cnt_q   <= half_q;
                    end else begin
                        cnt_q <= cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                CH_RUN: begin
                    if (cnt_q != {DIV_W{1'b0}}) begin
                        cnt_q <= cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
                    end else if (fall_toggle_s && pend_v_i) begin
                        // live update on the falling toggle; phase is ignored
                        out_q <= 1'b0;
                        if (pend_i.en) begin
                            half_q <= new_half_s;
                            cnt_q  <= new_half_s;
                        end else begin
                            state_q  <= CH_IDLE;
                            active_q <= 1'b0;
                            cnt_q    <= {DIV_W{1'b0}};
                        end
                    end else begin
                        out_q <= ~out_q;
                        cnt_q <= half_q;
                    end
                end
                default: begin
                    state_q  <= CH_IDLE;
                    cnt_q    <= {DIV_W{1'b0}};
                    out_q    <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_clk_o = out_q;
    assign active_o  = active_q;

endmodule

// File: rtl/ttdll_div_bank.sv
// ttdll_div_bank: NUM_CH programmable clock dividers configured over the
// three-wire tag interface.
//   clk, rst_n     : block clock, async active-low reset
//   tag_clk_i      : serial strobe (async), data shifted on its rising edge
//   tag_en_i       : frame enable (async), frame committed on its falling edge
//   tag_data_i     : serial data (async), MSB first: ch, en, half, phase
//   div_clk_o      : per-channel divided clocks (registered)
//   ch_active_o    : per-channel not-IDLE flags (registered)
//   cfg_err_o      : sticky bad-frame flag (wrong length or channel)
module ttdll_div_bank
    import ttdll_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tag_clk_i,
    input  logic              tag_en_i,
    input  logic              tag_data_i,
    output logic [NUM_CH-1:0] div_clk_o,
    output logic [NUM_CH-1:0] ch_active_o,
    output logic              cfg_err_o
);

    localparam int CH_W    = calc_ch_w(NUM_CH);
    localparam int FRAME_W = calc_frame_w(NUM_CH, DIV_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [SYNC_STAGES-1:0] tclk_sync_q;
    logic [SYNC_STAGES-1:0] ten_sync_q;
    logic [SYNC_STAGES-1:0] tdat_sync_q;
    logic                   tclk_prev_q;
    logic                   ten_prev_q;
    logic [FRAME_W-1:0]     shift_q;
    logic [CNT_W-1:0]       bitcnt_q;
    logic                   err_q;
    logic [NUM_CH-1:0]      pend_v_q;
    frame_t                 pend_q [NUM_CH];

    logic              tclk_s, ten_s, tdat_s;
    logic              rise_s, fall_s;
    logic [CH_W-1:0]   f_ch_s;
    logic              frame_ok_s;
    frame_t            new_frame_s;
    logic [NUM_CH-1:0] consume_s;

    assign tclk_s = tclk_sync_q[SYNC_STAGES-1];
    assign ten_s  = ten_sync_q[SYNC_STAGES-1];
    assign tdat_s = tdat_sync_q[SYNC_STAGES-1];
    assign rise_s = tclk_s & ~tclk_prev_q;
    assign fall_s = ten_prev_q & ~ten_s;
    assign f_ch_s = shift_q[FRAME_W-1 -: CH_W];
    // with a power-of-two NUM_CH every ch code is valid; only length can fail
    assign frame_ok_s = (bitcnt_q == CNT_FULL) && (32'(f_ch_s) < 32'(NUM_CH));

    // Unpack the shift register into the zero-extended frame struct
    always_comb begin
        new_frame_s                   = {$bits(frame_t){1'b0}};
        new_frame_s.ch[CH_W-1:0]      = f_ch_s;
        new_frame_s.en                = shift_q[2*DIV_W];
        new_frame_s.half[DIV_W-1:0]   = shift_q[2*DIV_W-1 -: DIV_W];
        new_frame_s.phase[DIV_W-1:0]  = shift_q[DIV_W-1:0];
    end

    // Tag input synchronisers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tclk_sync_q <= {SYNC_STAGES{1'b0}};
            ten_sync_q  <= {SYNC_STAGES{1'b0}};
            tdat_sync_q <= {SYNC_STAGES{1'b0}};
            tclk_prev_q <= 1'b0;
            ten_prev_q  <= 1'b0;
        end else begin
            tclk_sync_q <= {tclk_sync_q[SYNC_STAGES-2:0], tag_clk_i};
            ten_sync_q  <= {ten_sync_q[SYNC_STAGES-2:0], tag_en_i};
            tdat_sync_q <= {tdat_sync_q[SYNC_STAGES-2:0], tag_data_i};
            tclk_prev_q <= tclk_s;
            ten_prev_q  <= ten_s;
        end
    end

    // Frame shift register, saturating bit counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= {FRAME_W{1'b0}};
            bitcnt_q <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            if (fall_s) begin
                bitcnt_q <= {CNT_W{1'b0}};
                if (!frame_ok_s) begin
                    err_q <= 1'b1;
                end else begin
                    err_q <= err_q;
                end
            end else if (rise_s && ten_s) begin
                shift_q <= {shift_q[FRAME_W-2:0], tdat_s};
                // saturating one past FRAME_W flags over-long frames
                if (bitcnt_q != CNT_SAT) begin
                    bitcnt_q <= bitcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    bitcnt_q <= bitcnt_q;
                end
            end else begin
                bitcnt_q <= bitcnt_q;
            end
        end
    end

    // Pending-frame slots: a new frame overrides both an older one and a
    // same-cycle consume, so the last frame written always wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= {$bits(frame_t){1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fall_s && frame_ok_s && (f_ch_s == CH_W'(i))) begin
                    pend_v_q[i] <= 1'b1;
                    pend_q[i]   <= new_frame_s;
                end else if (consume_s[i]) begin
                    pend_v_q[i] <= 1'b0;
                end else begin
                    pend_v_q[i] <= pend_v_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ttdll_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pend_v_i  (pend_v_q[g]),
            .pend_i    (pend_q[g]),
            .consume_o (consume_s[g]),
            .div_clk_o (div_clk_o[g]),
            .active_o  (ch_active_o[g])
        );
    end

    assign cfg_err_o = err_q;

endmodule

// File: tb/tb_ttdll_div_bank.sv
`timescale 1ns/1ps
module tb_ttdll_div_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tag_clk = 1'b0;
    logic tag_data = 1'b0;
    logic tag_en = 1'b0;
    logic tag_en5 = 1'b0;
    logic [3:0] div, act;
    logic       err;
    logic [4:0] div5, act5;
    logic       err5;

    ttdll_div_bank #(.NUM_CH(4), .DIV_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .tag_clk_i(tag_clk), .tag_en_i(tag_en),
        .tag_data_i(tag_data), .div_clk_o(div), .ch_active_o(act), .cfg_err_o(err));

    // 5-channel instance so that an out-of-range channel code is encodable
    ttdll_div_bank #(.NUM_CH(5), .DIV_W(8), .SYNC_STAGES(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .tag_clk_i(tag_clk), .tag_en_i(tag_en5),
        .tag_data_i(tag_data), .div_clk_o(div5), .ch_active_o(act5), .cfg_err_o(err5));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int BIG = 1 << 30;
    // event times (cycle count at the en-fall pin edge) for the model
    int f_ch0 = BIG, f_ch1 = BIG, f_ch2 = BIG, f_ch3 = BIG, f_ch4 = BIG;
    int sw1 = BIG, sw2 = BIG, err_cyc = BIG, err5_cyc = BIG;
    int pass_cnt = 0, total_cnt = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        bit          is5;
    } sb_t;
    sb_t sb_q [$];

    // Expected {div, act, err} of the 4-channel DUT after clock edge c
    function automatic logic [15:0] exp_main(input int c);
        logic [3:0] d, a;
        logic e;
        int k;
        d = 4'd0; a = 4'd0;
        if (c >= f_ch0 + 4 && c < sw2) begin
            a[0] = 1'b1;
            if (c >= sw1) d[0] = (((c - sw1) / 5) % 2) == 1;
            else if (c >= f_ch0 + 5) d[0] = ((c - f_ch0 - 5) % 2) == 0;
        end
        if (c >= f_ch1 + 4) begin
            a[1] = 1'b1;
            if (c >= f_ch1 + 8) d[1] = ((c - f_ch1 - 8) % 6) < 3;
        end
        if (c >= f_ch2 + 4) begin
            a[2] = 1'b1;
            k = c - f_ch2;
            if (k == 260) d[2] = 1'b1;
            else if (k >= 261) d[2] = (((k - 261) / 3) % 2) == 1;
        end
        if (c >= f_ch3 + 4) begin
            a[3] = 1'b1;
            if (c >= f_ch3 + 6) d[3] = ((c - f_ch3 - 6) % 4) < 2;
        end
        e = (c >= err_cyc);
        return {7'd0, d, a, e};
    endfunction

    function automatic logic [15:0] exp5(input int c);
        logic [4:0] d, a;
        logic e;
        d = 5'd0; a = 5'd0;
        if (c >= f_ch4 + 4) begin
            a[4] = 1'b1;
            if (c >= f_ch4 + 5) d[4] = ((c - f_ch4 - 5) % 4) < 2;
        end
        e = (c >= err5_cyc);
        return {5'd0, d, a, e};
    endfunction

    function automatic logic [31:0] frm(input logic [2:0] ch, input logic en,
                                        input logic [7:0] h, input logic [7:0] p,
                                        input bit wide);
        if (wide) return {12'd0, ch, en, h, p};
        return {13'd0, ch[1:0], en, h, p};
    endfunction

    task automatic send(input bit to5, input logic [31:0] bits, input int n);
        @(negedge clk);
        if (to5) tag_en5 = 1'b1; else tag_en = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            tag_data = bits[i];
            repeat (3) @(negedge clk);
            tag_clk = 1'b1;
            repeat (3) @(negedge clk);
            tag_clk = 1'b0;
        end
        repeat (3) @(negedge clk);
        tag_en = 1'b0;
        tag_en5 = 1'b0;
        tag_data = 1'b0;
    endtask

    task automatic arm(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            sb_q.push_back('{tag, exp_main(cyc + i), 1'b0});
            sb_q.push_back('{tag, exp5(cyc + i), 1'b1});
        end
    endtask

    task automatic check_pop();
        sb_t e;
        logic [15:0] obs;
        total_cnt++;
        if (sb_q.size() == 0) begin
            $error("FAIL sb_empty: got 0 entries want 1");
            return;
        end
        e = sb_q.pop_front();
        obs = e.is5 ? {5'd0, div5, act5, err5} : {7'd0, div, act, err};
        assert (obs === e.exp) pass_cnt++;
        else $error("FAIL %s cyc=%0d dut5=%0d: got %h want %h", e.tag, cyc, e.is5, obs, e.exp);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_pop();
            check_pop();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j, c;
        bit hit;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        arm("reset", 3); run(3);

        send(1'b0, frm(3'd1, 1'b1, 8'd2, 8'd3, 1'b0), 19);
        f_ch1 = cyc; arm("ch1_start", 30); run(30);

        send(1'b0, frm(3'd0, 1'b1, 8'd0, 8'd0, 1'b0), 19);
        f_ch0 = cyc; arm("ch0_start", 20); run(20);

        // live update waits for the next falling toggle (ch0 high on odd k)
        send(1'b0, frm(3'd0, 1'b1, 8'd4, 8'd0, 1'b0), 19);
        j = cyc + 3 - f_ch0;
        if ((j % 2) == 0) j++;
        sw1 = f_ch0 + j + 1;
        arm("ch0_h4", 40); run(40);

        // disable lands after the last high cycle of a 5-high/5-low period
        send(1'b0, frm(3'd0, 1'b0, 8'd0, 8'd0, 1'b0), 19);
        c = cyc + 3;
        while (((c - sw1) % 10) != 9) c++;
        sw2 = c + 1;
        arm("ch0_off", 25); run(25);

        send(1'b0, frm(3'd2, 1'b1, 8'd1, 8'd1, 1'b0), 18);
        err_cyc = cyc + 3; arm("err_short", 10); run(10);
        send(1'b0, frm(3'd2, 1'b1, 8'd1, 8'd1, 1'b0), 20);
        arm("err_long", 10); run(10);
        send(1'b0, frm(3'd3, 1'b1, 8'd1, 8'd1, 1'b0), 19);
        f_ch3 = cyc; arm("ch3_after_err", 20); run(20);

        send(1'b1, frm(3'd5, 1'b1, 8'd1, 8'd0, 1'b1), 20);
        err5_cyc = cyc + 3; arm("err_ch5", 10); run(10);
        send(1'b1, frm(3'd4, 1'b1, 8'd1, 8'd0, 1'b1), 20);
        f_ch4 = cyc; arm("ch4_after_err", 15); run(15);

        // two frames land while ch2 is still in its 256-cycle hold
        send(1'b0, frm(3'd2, 1'b1, 8'd0, 8'd255, 1'b0), 19);
        f_ch2 = cyc; arm("ch2_hold", 3); run(3);
        send(1'b0, frm(3'd2, 1'b1, 8'd5, 8'd0, 1'b0), 19);
        arm("ch2_f1", 3); run(3);
        send(1'b0, frm(3'd2, 1'b1, 8'd2, 8'd0, 1'b0), 19);
        arm("ch2_f2", 70); run(70);

        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (div[1]) begin
                hit = 1'b1;
                break;
            end
        end
        total_cnt++;
        assert (hit === 1'b1) pass_cnt++;
        else $error("FAIL async_wait: got %b want 1", hit);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        assert ({div, act, err} === 9'd0) pass_cnt++;
        else $error("FAIL async_rst: got %h want 000", {div, act, err});
        total_cnt++;
        assert ({div5, act5, err5} === 11'd0) pass_cnt++;
        else $error("FAIL async_rst5: got %h want 000", {div5, act5, err5});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
